// File: rtl/wb_sram_slave_pkg.sv
// wb_sram_slave_pkg: shared constants, FSM state type and burst index helper for wb_sram_slave.
package wb_sram_slave_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;
    typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_t;
    // Linear increments freely; callers truncate to the memory depth, which gives the wrap at depth.
    function automatic logic [31:0] next_index(input logic [31:0] idx, input logic [1:0] bte);
        logic [31:0] m;
        m = bte == BTE_WRAP4 ? 32'd3 : bte == BTE_WRAP8 ? 32'd7 : bte == BTE_WRAP16 ? 32'd15 : '1;
        return (idx & ~m) | ((idx + 32'd1) & m);
    endfunction
endpackage

// File: rtl/wb_sram_slave_if.sv
// wb_sram_slave_if: Wishbone bus bundle with master and slave views.
interface wb_sram_slave_if #(parameter int AW = 32, parameter int DW = 32);
    logic [AW-1:0]   ADR;
    logic [DW-1:0]   DAT_W;
    logic [DW-1:0]   DAT_R;
    logic            CYC;
    logic            STB;
    logic            WE;
    logic [DW/8-1:0] SEL;
    logic [2:0]      CTI;
    logic [1:0]      BTE;
    logic            ACK;
    logic            ERR;
    modport master(output ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE, input DAT_R, ACK, ERR);
    modport slave(input ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE, output DAT_R, ACK, ERR);
endinterface

// File: rtl/wb_sram_slave_mem.sv
// wb_sram_slave_mem: byte-enable word RAM, synchronous write, asynchronous read, contents never reset.
module wb_sram_slave_mem #(parameter int DW = 32, parameter int AB = 10) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [DW/8-1:0] i_sel,
    input  logic [AB-1:0]   i_wa,
    input  logic [AB-1:0]   i_ra,
    input  logic [DW-1:0]   i_wd,
    output logic [DW-1:0]   o_rd
);
    logic [DW-1:0] r_mem [2**AB];
    always_ff @(posedge clk)
        for (int b = 0; b < DW/8; b++)
            if (i_we && i_sel[b]) r_mem[i_wa][8*b +: 8] <= i_wd[8*b +: 8];
    assign o_rd = r_mem[i_ra];
endmodule

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone SRAM slave with wait states and decode-miss ERR.
// Define WB_SRAM_SLAVE_BURST_EN for registered-feedback CTI/BTE bursts.
module wb_sram_slave import wb_sram_slave_pkg::*; #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                       WAIT_STATES   = 1
) (
    input logic            clk,
    input logic            rstn,
    wb_sram_slave_if.slave bus
);
    localparam int AL = $clog2(WB_DATA_WIDTH/8);
    localparam int HI = MEM_ADDR_BITS + AL;
    state_t                   r_state;
    logic [3:0]               r_cnt;
    logic                     r_ack, r_err;
    logic [WB_DATA_WIDTH-1:0] r_dat, w_mem, w_rd;
    logic [MEM_ADDR_BITS-1:0] w_idx, w_ra, w_wa;
    logic                     w_hit, w_we, w_fire, w_unused;
    assign w_hit  = bus.ADR[WB_ADDR_WIDTH-1:HI] == BASE_ADDR[WB_ADDR_WIDTH-1:HI];
    assign w_idx  = bus.ADR[HI-1:AL];
    assign w_fire = bus.STB && ((r_state == IDLE && WAIT_STATES == 0) || (r_state == WAIT && r_cnt == 4'd1));
`ifdef WB_SRAM_SLAVE_BURST_EN
    logic [MEM_ADDR_BITS-1:0] r_idx, w_nxt;
    logic [31:0]              w_n32;
    logic                     w_go, w_bad, w_done;
    assign w_go   = r_state == RESP && r_ack && bus.CTI == CTI_INCR;
    assign w_bad  = r_state == BURST && bus.STB && (bus.CTI == CTI_CLASSIC || !w_hit);
    assign w_done = r_state == BURST && bus.STB && r_ack && !w_bad;
    assign w_n32  = next_index(32'(w_go ? w_idx : r_idx), bus.BTE);
    assign w_nxt  = w_n32[MEM_ADDR_BITS-1:0];
    // Read side looks one beat ahead so DAT_R is registered for the next ACK.
    assign w_ra   = w_go || w_done ? w_nxt : r_state == BURST ? r_idx : w_idx;
    assign w_wa   = r_state == BURST ? r_idx : w_idx;
    assign w_we   = bus.CYC && bus.WE && ((r_state == RESP && r_ack) || w_done);
    assign w_unused = ^{w_n32, bus.ADR};
`else
    assign w_ra   = w_idx;
    assign w_wa   = w_idx;
    assign w_we   = bus.CYC && bus.WE && r_state == RESP && r_ack;
    assign w_unused = ^{bus.CTI, bus.BTE, bus.ADR};
`endif
    wb_sram_slave_mem #(.DW(WB_DATA_WIDTH), .AB(MEM_ADDR_BITS)) u_mem (
        .clk(clk), .i_we(w_we), .i_sel(bus.SEL), .i_wa(w_wa), .i_ra(w_ra), .i_wd(bus.DAT_W), .o_rd(w_mem)
    );
    always_comb begin
        w_rd = w_mem;
        for (int b = 0; b < WB_DATA_WIDTH/8; b++)
            if (w_we && bus.SEL[b] && w_wa == w_ra) w_rd[8*b +: 8] = bus.DAT_W[8*b +: 8];
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
`ifdef WB_SRAM_SLAVE_BURST_EN
            r_idx   <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
            if (!bus.CYC) r_state <= IDLE;
            else if (w_fire) begin
                r_state <= RESP;
                r_cnt   <= '0;
                r_ack   <= w_hit;
                r_err   <= !w_hit;
                r_dat   <= w_hit ? w_rd : '0;
            end else case (r_state)
                IDLE: if (bus.STB) begin
                    r_state <= WAIT;
                    r_cnt   <= 4'(WAIT_STATES);
                end
                WAIT: if (bus.STB) r_cnt <= r_cnt - 4'd1;
`ifdef WB_SRAM_SLAVE_BURST_EN
                RESP: if (w_go) begin
                    r_state <= BURST;
                    r_idx   <= w_nxt;
                    r_ack   <= 1'b1;
                    r_dat   <= w_rd;
                end else r_state <= IDLE;
                BURST: if (w_bad) begin
                    r_state <= RESP;
                    r_err   <= 1'b1;
                end else if (w_done && bus.CTI == CTI_END) r_state <= IDLE;
                else begin
                    if (w_done) r_idx <= w_nxt;
                    r_ack <= bus.STB;
                    r_dat <= bus.STB ? w_rd : '0;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.ACK   = r_ack;
    assign bus.ERR   = r_err;
    assign bus.DAT_R = r_dat;
endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: directed bench for wb_sram_slave; u0 has one wait state, u1 none.
module tb_wb_sram_slave;
    import wb_sram_slave_pkg::*;
    logic clk = 0, rstn = 0, use1 = 0;
    always #5 clk = ~clk;
    logic [31:0] m_adr = 0, m_dat = 0;
    logic        m_cyc = 0, m_stb = 0, m_we = 0;
    logic [3:0]  m_sel = 0;
    logic [2:0]  m_cti = 0;
    logic [1:0]  m_bte = 0;
    int checks = 0, errors = 0;
    wb_sram_slave_if b0();
    wb_sram_slave_if b1();
    assign b0.ADR = m_adr;  assign b1.ADR = m_adr;
    assign b0.DAT_W = m_dat; assign b1.DAT_W = m_dat;
    assign b0.WE = m_we;    assign b1.WE = m_we;
    assign b0.SEL = m_sel;  assign b1.SEL = m_sel;
    assign b0.CTI = m_cti;  assign b1.CTI = m_cti;
    assign b0.BTE = m_bte;  assign b1.BTE = m_bte;
    assign b0.CYC = m_cyc & ~use1; assign b1.CYC = m_cyc & use1;
    assign b0.STB = m_stb & ~use1; assign b1.STB = m_stb & use1;
    wire        w_ack = use1 ? b1.ACK : b0.ACK;
    wire        w_err = use1 ? b1.ERR : b0.ERR;
    wire [31:0] w_dr  = use1 ? b1.DAT_R : b0.DAT_R;
    wb_sram_slave #(.WAIT_STATES(1)) u0 (.clk(clk), .rstn(rstn), .bus(b0));
    wb_sram_slave #(.WAIT_STATES(0)) u1 (.clk(clk), .rstn(rstn), .bus(b1));

    always @(negedge clk)
        if ((b0.ACK && b0.ERR) || (b1.ACK && b1.ERR)) begin
            errors++;
            $display("FAIL ack_err_exclusive: ACK and ERR both 1 at %0t", $time);
        end

    task automatic xfer(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] d,
                        input logic [2:0] cti, output int lat, output logic ak, output logic er, output logic [31:0] q);
        @(negedge clk);
        m_adr = a; m_we = we; m_sel = s; m_dat = d; m_cti = cti; m_cyc = 1; m_stb = 1;
        lat = 0; ak = 0; er = 0; q = '0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (w_ack || w_err) begin lat = i; ak = w_ack; er = w_err; q = w_dr; end
        end
        @(posedge clk); #1;
        m_cyc = 0; m_stb = 0; m_we = 0; m_cti = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", w_ack); end
        checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", w_err); end
        checks++; if (w_dr !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", w_dr); end
        rstn = 1;
    endtask

    task automatic test_write_read();
        int lat; logic ak, er; logic [31:0] q;
        xfer(32'h10, 1, 4'hF, 32'hDEADBEEF, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (ak !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b expected 1", ak); end
        checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        xfer(32'h10, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", er); end
        checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", q); end
    endtask

    task automatic test_byte_sel();
        int lat; logic ak, er; logic [31:0] q;
        xfer(32'h20, 1, 4'hF, 32'h11223344, CTI_CLASSIC, lat, ak, er, q);
        xfer(32'h20, 1, 4'h1, 32'h000000AA, CTI_CLASSIC, lat, ak, er, q);
        xfer(32'h20, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (q !== 32'h112233AA) begin errors++; $display("FAIL sel_lane0: got %h expected 112233aa", q); end
        xfer(32'h22, 1, 4'h4, 32'h00550000, CTI_CLASSIC, lat, ak, er, q);
        xfer(32'h20, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (q !== 32'h115533AA) begin errors++; $display("FAIL sel_lane2: got %h expected 115533aa", q); end
    endtask

    task automatic test_miss();
        int lat; logic ak, er; logic [31:0] q;
        xfer(32'h0, 1, 4'hF, 32'hCAFEF00D, CTI_CLASSIC, lat, ak, er, q);
        xfer(32'h1000, 1, 4'hF, 32'h00000BAD, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL miss_wr_err: got %b expected 1", er); end
        checks++; if (ak !== 1'b0) begin errors++; $display("FAIL miss_wr_ack: got %b expected 0", ak); end
        xfer(32'h1000, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (er !== 1'b1 || q !== 32'h0) begin errors++; $display("FAIL miss_rd: got err=%b dat=%h expected err=1 dat=0", er, q); end
        checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL miss_err_one_cycle: got %b expected 0", w_err); end
        xfer(32'h0, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (q !== 32'hCAFEF00D) begin errors++; $display("FAIL miss_mem_kept: got %h expected cafef00d", q); end
    endtask

    task automatic test_wait_hold();
        @(negedge clk);
        m_adr = 32'h10; m_we = 0; m_sel = 4'hF; m_cyc = 1; m_stb = 1;
        @(negedge clk);
        m_stb = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL hold_no_ack: got %b expected 0", w_ack); end
        end
        m_stb = 1;
        @(negedge clk);
        checks++; if (w_ack !== 1'b1 || w_dr !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_resume: got ack=%b dat=%h expected ack=1 dat=deadbeef", w_ack, w_dr); end
        @(posedge clk); #1;
        m_cyc = 0; m_stb = 0;
    endtask

    task automatic test_cyc_abort();
        int lat; logic ak, er; logic [31:0] q;
        xfer(32'h40, 1, 4'hF, 32'h11111111, CTI_CLASSIC, lat, ak, er, q);
        @(negedge clk);
        m_adr = 32'h40; m_we = 1; m_dat = 32'h22222222; m_cyc = 1; m_stb = 1;
        @(negedge clk);
        m_cyc = 0; m_stb = 0; m_we = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got %b expected 0", w_ack); end
        end
        xfer(32'h40, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (q !== 32'h11111111) begin errors++; $display("FAIL abort_no_write: got %h expected 11111111", q); end
    endtask

    task automatic test_reset_in_resp();
        int lat; logic ak, er; logic [31:0] q;
        xfer(32'h44, 1, 4'hF, 32'h44444444, CTI_CLASSIC, lat, ak, er, q);
        @(negedge clk);
        m_adr = 32'h44; m_we = 1; m_dat = 32'h99999999; m_cyc = 1; m_stb = 1;
        lat = 0;
        for (int i = 1; i <= 5 && lat == 0; i++) begin @(negedge clk); if (w_ack) lat = i; end
        checks++; if (lat != 2) begin errors++; $display("FAIL rst_pre_ack: got %0d expected 2", lat); end
        rstn = 0; #1;
        checks++; if (w_ack !== 1'b0 || w_err !== 1'b0 || w_dr !== 32'h0) begin errors++; $display("FAIL rst_async: got ack=%b err=%b dat=%h expected 0", w_ack, w_err, w_dr); end
        m_cyc = 0; m_stb = 0; m_we = 0;
        @(negedge clk); rstn = 1;
        xfer(32'h44, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (q !== 32'h44444444) begin errors++; $display("FAIL rst_no_write: got %h expected 44444444", q); end
        xfer(32'h10, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_retained: got %h expected deadbeef", q); end
    endtask

`ifdef WB_SRAM_SLAVE_BURST_EN
    task automatic test_burst();
        int lat; logic ak, er; logic [31:0] q;
        logic [31:0] exp_w [4] = '{32'd3, 32'd4, 32'd1, 32'd2};
        @(negedge clk);
        m_adr = 32'h08; m_we = 1; m_sel = 4'hF; m_dat = 1; m_cti = CTI_INCR; m_bte = BTE_WRAP4; m_cyc = 1; m_stb = 1;
        lat = 0;
        for (int i = 1; i <= 5 && lat == 0; i++) begin @(negedge clk); if (w_ack) lat = i; end
        checks++; if (lat != 2) begin errors++; $display("FAIL burst_first_ack: got %0d expected 2", lat); end
        for (int b = 2; b <= 4; b++) begin
            @(posedge clk); #1;
            m_adr = 32'((8 + 4 * (b - 1)) % 16); m_dat = 32'(b); m_cti = b == 4 ? CTI_END : CTI_INCR;
            @(negedge clk);
            checks++; if (w_ack !== 1'b1) begin errors++; $display("FAIL burst_ack_beat%0d: got %b expected 1", b, w_ack); end
        end
        @(posedge clk); #1;
        m_cyc = 0; m_stb = 0; m_we = 0; m_cti = 0; m_bte = 0;
        @(negedge clk);
        checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL burst_end: got %b expected 0", w_ack); end
        for (int w = 0; w < 4; w++) begin
            xfer(32'(4 * w), 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
            checks++; if (q !== exp_w[w]) begin errors++; $display("FAIL burst_word%0d: got %h expected %h", w, q, exp_w[w]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat; logic ak, er; logic [31:0] q;
        xfer(32'h58, 1, 4'hF, 32'h58585858, CTI_CLASSIC, lat, ak, er, q);
        @(negedge clk);
        m_adr = 32'h54; m_we = 1; m_dat = 32'hA1; m_cti = CTI_INCR; m_bte = BTE_WRAP4; m_cyc = 1; m_stb = 1;
        lat = 0;
        for (int i = 1; i <= 5 && lat == 0; i++) begin @(negedge clk); if (w_ack) lat = i; end
        @(posedge clk); #1;
        m_adr = 32'h58; m_dat = 32'hA2;
        @(negedge clk);
        checks++; if (w_ack !== 1'b1) begin errors++; $display("FAIL mid_burst_ack: got %b expected 1", w_ack); end
        rstn = 0; #1;
        checks++; if (w_ack !== 1'b0 || w_err !== 1'b0 || w_dr !== 32'h0) begin errors++; $display("FAIL mid_burst_rst: got ack=%b err=%b dat=%h expected 0", w_ack, w_err, w_dr); end
        m_cyc = 0; m_stb = 0; m_we = 0; m_cti = 0; m_bte = 0;
        @(negedge clk); rstn = 1;
        xfer(32'h54, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (q !== 32'hA1) begin errors++; $display("FAIL mid_burst_beat1: got %h expected a1", q); end
        xfer(32'h58, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (q !== 32'h58585858) begin errors++; $display("FAIL mid_burst_no_write: got %h expected 58585858", q); end
    endtask
`else
    task automatic test_cti_ignored();
        int lat; logic ak, er; logic [31:0] q;
        m_bte = BTE_WRAP4;
        xfer(32'h08, 1, 4'hF, 32'h00000101, CTI_INCR, lat, ak, er, q);
        checks++; if (ak !== 1'b1 || lat != 2) begin errors++; $display("FAIL cti_classic_ack: got ack=%b lat=%0d expected 1/2", ak, lat); end
        @(negedge clk);
        checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL cti_single_ack: got %b expected 0", w_ack); end
        m_bte = 0;
        xfer(32'h08, 0, 4'hF, 32'h0, CTI_CLASSIC, lat, ak, er, q);
        checks++; if (q !== 32'h00000101) begin errors++; $display("FAIL cti_data: got %h expected 00000101", q); end
    endtask
`endif

    task automatic test_back_to_back();
        int lat, k; logic ak, er; logic [31:0] q;
        use1 = 1;
        for (int w = 0; w < 4; w++) begin
            xfer(32'(4 * w), 1, 4'hF, 32'hB0 + 32'(w), CTI_CLASSIC, lat, ak, er, q);
            if (w == 0) begin checks++; if (lat != 1) begin errors++; $display("FAIL ws0_latency: got %0d expected 1", lat); end end
        end
        @(negedge clk);
        m_adr = 0; m_we = 0; m_sel = 4'hF; m_cyc = 1; m_stb = 1; k = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (w_ack !== c[0]) begin errors++; $display("FAIL b2b_ack_cycle%0d: got %b expected %b", c, w_ack, c[0]); end
            if (w_ack) begin
                checks++; if (w_dr !== 32'hB0 + 32'(k)) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, w_dr, 32'hB0 + 32'(k)); end
                k++; m_adr = 32'(4 * k);
            end
        end
        m_cyc = 0; m_stb = 0;
        @(negedge clk);
        use1 = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_sel();
        test_miss();
        test_wait_hold();
        test_cyc_abort();
        test_reset_in_resp();
`ifdef WB_SRAM_SLAVE_BURST_EN
        test_burst();
        test_reset_mid_burst();
`else
        test_cti_ignored();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
